rfrom_bist_arb: RTL and testbench

Access controller for the 2048x16 register-file ROM. Shares the single ROM read port between the functional requester and an on-block BIST engine that sweeps every address and compresses the read data into a MISR signature. Sits between the ROM macro and its functional client. Takes the already-synchronized MBIST enable from the ROM wrapper's enable synchronizer.

---
 rtl/rfrom_pkg.sv | 34 +++
 rtl/rfrom_bist_misr.sv | 38 +++
 rtl/rfrom_bist_arb.sv | 189 ++++++++++++++++++
 tb/tb_rfrom_bist_arb.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfrom_pkg.sv
// Shared types and helpers for the register-file ROM access controller and its BIST MISR.
package rfrom_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRun,
        StFlush,
        StDone
    } rfrom_state_e;

    localparam logic [15:0] MisrPolyDefault = 16'h100B;
    localparam int unsigned MisrMaxW = 32;

    // One MISR step at an arbitrary width up to MisrMaxW; bits above `width` come back zero.
    function automatic logic [MisrMaxW-1:0] misr_step(
        input logic [MisrMaxW-1:0] sig,
        input logic [MisrMaxW-1:0] din,
        input logic [MisrMaxW-1:0] poly,
        input int unsigned         width
    );
        logic [MisrMaxW-1:0] mask;
        logic [MisrMaxW-1:0] nxt;
        logic [4:0]          msb_idx;
        mask    = (width >= MisrMaxW) ? '1 : ((MisrMaxW'(1) << width) - MisrMaxW'(1));
        msb_idx = 5'(width - 1);
        nxt     = sig << 1;
        if (sig[msb_idx]) begin
            nxt = nxt ^ poly;
        end
        return (nxt ^ din) & mask;
    endfunction

endpackage

// File: rtl/rfrom_bist_misr.sv
// Signature register for the ROM BIST: synchronous clear, enable-gated MISR compression.
module rfrom_bist_misr
    import rfrom_pkg::*;
#(
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] MISR_POLY = DATA_W'(MisrPolyDefault)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sig
);

    logic [DATA_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = DATA_W'(misr_step(MisrMaxW'(sig_q), MisrMaxW'(din), MisrMaxW'(MISR_POLY),
                                      DATA_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/rfrom_bist_arb.sv
// Shares the ROM read port between the functional client and a sweeping MISR BIST engine.
// Define RFROM_BIST_CMP_EN to add bist_exp_sig and the registered bist_pass comparator.
module rfrom_bist_arb
    import rfrom_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 11,
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       DEPTH     = 2048,
    parameter int unsigned       RD_LAT    = 1,
    parameter logic [DATA_W-1:0] MISR_POLY = DATA_W'(MisrPolyDefault)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fn_req,
    input  logic [ADDR_W-1:0] fn_addr,
    output logic              fn_gnt,
    output logic              fn_rvalid,
    output logic [DATA_W-1:0] fn_rdata,
    input  logic              bist_en,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic [DATA_W-1:0] bist_sig,
`ifdef RFROM_BIST_CMP_EN
    input  logic [DATA_W-1:0] bist_exp_sig,
`endif
    output logic              bist_pass,
    output logic              rom_ren,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout
);

    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        FlushLast = 2'(RD_LAT - 1);

    rfrom_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        flush_q, flush_d;
    logic              abort_q, abort_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [RD_LAT-1:0] fn_vld_q, fn_vld_d;
    logic [RD_LAT-1:0] bist_vld_q, bist_vld_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fn_issue, bist_issue, start_ok, done_enter, pipe_empty;

    assign pipe_empty = ((fn_vld_q | bist_vld_q) == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        abort_d    = abort_q;
        fn_gnt     = 1'b0;
        rom_ren    = 1'b0;
        rom_addr   = '0;
        fn_issue   = 1'b0;
        bist_issue = 1'b0;
        start_ok   = 1'b0;
        done_enter = 1'b0;
        unique case (state_q)
            StIdle: begin
                fn_gnt   = fn_req;
                rom_ren  = fn_req;
                rom_addr = fn_addr;
                fn_issue = fn_req;
                if (bist_start && bist_en) begin
                    start_ok = 1'b1;
                    abort_d  = 1'b0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (pipe_empty) begin
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                flush_d = '0;
                if (!bist_en) begin
                    abort_d = 1'b1;
                    state_d = StFlush;
                end else begin
                    rom_ren    = 1'b1;
                    rom_addr   = cnt_q;
                    bist_issue = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == LastAddr) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                flush_d = flush_q + 1'b1;
                if (flush_q == FlushLast) begin
                    done_enter = !abort_q;
                    state_d    = abort_q ? StIdle : StDone;
                end
            end
            StDone: begin
                if (!bist_en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        done_d     = start_ok ? 1'b0 : (done_enter ? 1'b1 : done_q);
        busy_d     = (state_d == StWait) || (state_d == StRun) || (state_d == StFlush);
        fn_vld_d   = (fn_vld_q << 1) | RD_LAT'(fn_issue);
        bist_vld_d = (bist_vld_q << 1) | RD_LAT'(bist_issue);
        rdata_d    = fn_vld_q[RD_LAT-1] ? rom_dout : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            flush_q    <= '0;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            fn_vld_q   <= '0;
            bist_vld_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            abort_q    <= abort_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            fn_vld_q   <= fn_vld_d;
            bist_vld_q <= bist_vld_d;
            rdata_q    <= rdata_d;
        end
    end

    // rom_dout is only present during the return cycle, so it is passed through then and held.
    assign fn_rvalid = fn_vld_q[RD_LAT-1];
    assign fn_rdata  = fn_rvalid ? rom_dout : rdata_q;
    assign bist_busy = busy_q;
    assign bist_done = done_q;

    rfrom_bist_misr #(
        .DATA_W   (DATA_W),
        .MISR_POLY(MISR_POLY)
    ) u_misr (
        .clk(clk),
        .rst(rst),
        .clr(start_ok),
        .en (bist_vld_q[RD_LAT-1]),
        .din(rom_dout),
        .sig(bist_sig)
    );

`ifdef RFROM_BIST_CMP_EN
    logic              pass_q, pass_d;
    logic [DATA_W-1:0] sig_final;

    // The final return folds into the MISR on the same edge that enters DONE.
    always_comb begin
        sig_final = DATA_W'(misr_step(MisrMaxW'(bist_sig), MisrMaxW'(rom_dout),
                                      MisrMaxW'(MISR_POLY), DATA_W));
        pass_d = pass_q;
        if (start_ok) begin
            pass_d = 1'b0;
        end else if (done_enter) begin
            pass_d = (sig_final == bist_exp_sig);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
        end
    end

    assign bist_pass = pass_q;
`else
    assign bist_pass = 1'b0;
`endif

endmodule

// File: tb/tb_rfrom_bist_arb.sv
// Directed bench for rfrom_bist_arb: one DUT at RD_LAT=1 and one at RD_LAT=2 on shared stimulus.
module tb_rfrom_bist_arb;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 16;
`ifdef RFROM_BIST_CMP_EN
    localparam bit CmpEn = 1'b1;
`else
    localparam bit CmpEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fn_req = 1'b0;
    logic [AW-1:0] fn_addr = '0;
    logic          bist_en = 1'b0;
    logic          bist_start = 1'b0;
    logic [DW-1:0] exp_sig = '0;

    logic          fn_gnt1, fn_rvalid1, bist_busy1, bist_done1, bist_pass1, rom_ren1;
    logic [DW-1:0] fn_rdata1, bist_sig1, rom_dout1;
    logic [AW-1:0] rom_addr1;
    logic          fn_gnt2, fn_rvalid2, bist_busy2, bist_done2, bist_pass2, rom_ren2;
    logic [DW-1:0] fn_rdata2, bist_sig2, rom_dout2;
    logic [AW-1:0] rom_addr2;

    // ROM image: all zero except one hot word.
    logic [AW-1:0] hot_a = '0;
    logic [DW-1:0] hot_d = '0;
    logic [DW-1:0] p1 = '0, p2a = '0, p2b = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return (a == hot_a) ? hot_d : '0;
    endfunction

    always @(posedge clk) begin
        p1  <= rom_word(rom_addr1);
        p2a <= rom_word(rom_addr2);
        p2b <= p2a;
    end
    assign rom_dout1 = p1;
    assign rom_dout2 = p2b;

    rfrom_bist_arb #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .fn_req(fn_req), .fn_addr(fn_addr), .fn_gnt(fn_gnt1),
        .fn_rvalid(fn_rvalid1), .fn_rdata(fn_rdata1), .bist_en(bist_en),
        .bist_start(bist_start), .bist_busy(bist_busy1), .bist_done(bist_done1),
        .bist_sig(bist_sig1),
`ifdef RFROM_BIST_CMP_EN
        .bist_exp_sig(exp_sig),
`endif
        .bist_pass(bist_pass1), .rom_ren(rom_ren1), .rom_addr(rom_addr1), .rom_dout(rom_dout1)
    );

    rfrom_bist_arb #(.RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .fn_req(fn_req), .fn_addr(fn_addr), .fn_gnt(fn_gnt2),
        .fn_rvalid(fn_rvalid2), .fn_rdata(fn_rdata2), .bist_en(bist_en),
        .bist_start(bist_start), .bist_busy(bist_busy2), .bist_done(bist_done2),
        .bist_sig(bist_sig2),
`ifdef RFROM_BIST_CMP_EN
        .bist_exp_sig(exp_sig),
`endif
        .bist_pass(bist_pass2), .rom_ren(rom_ren2), .rom_addr(rom_addr2), .rom_dout(rom_dout2)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1; fn_req = 1'b0; fn_addr = '0; bist_en = 1'b0; bist_start = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        rst = 1'b1; fn_req = 1'b0; fn_addr = '0; bist_en = 1'b0; bist_start = 1'b0;
        sample();
        checks++;
        if ({fn_gnt1, fn_rvalid1, fn_rdata1, bist_busy1, bist_done1, bist_sig1, bist_pass1,
             rom_ren1, rom_addr1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_lat1 got %0h %0h %0h %0h %0h %0h want all 0", fn_gnt1,
                     fn_rvalid1, bist_busy1, bist_done1, bist_sig1, rom_ren1);
        end
        checks++;
        if ({fn_gnt2, fn_rvalid2, fn_rdata2, bist_busy2, bist_done2, bist_sig2, bist_pass2,
             rom_ren2, rom_addr2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_lat2 got %0h %0h %0h %0h want all 0", fn_rvalid2,
                     bist_busy2, bist_done2, bist_sig2);
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_functional();
        next_cycle();
        hot_a = 11'h005; hot_d = 16'hBEEF; fn_req = 1'b1; fn_addr = 11'h005;
        sample();
        checks++;
        if ({fn_gnt1, rom_ren1, rom_addr1} !== {1'b1, 1'b1, 11'h005}) begin
            errors++;
            $display("FAIL fn_grant got gnt=%0b ren=%0b addr=%0h want 1 1 005", fn_gnt1,
                     rom_ren1, rom_addr1);
        end
        checks++;
        if (fn_rvalid1 !== 1'b0) begin
            errors++;
            $display("FAIL fn_rvalid_early got %0b want 0", fn_rvalid1);
        end
        next_cycle();
        fn_req = 1'b0; fn_addr = 11'h007;
        sample();
        checks++;
        if ({fn_rvalid1, fn_rdata1, fn_gnt1} !== {1'b1, 16'hBEEF, 1'b0}) begin
            errors++;
            $display("FAIL fn_return got vld=%0b data=%0h gnt=%0b want 1 beef 0", fn_rvalid1,
                     fn_rdata1, fn_gnt1);
        end
        next_cycle();
        fn_req = 1'b1; fn_addr = 11'h006;
        sample();
        checks++;
        if ({fn_rvalid1, fn_rdata1} !== {1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL fn_hold got vld=%0b data=%0h want 0 beef", fn_rvalid1, fn_rdata1);
        end
        next_cycle();
        fn_req = 1'b0;
        sample();
        checks++;
        if ({fn_rvalid1, fn_rdata1} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL fn_second got vld=%0b data=%0h want 1 0000", fn_rvalid1, fn_rdata1);
        end
    endtask

    // Full sweep on both DUTs; expected latencies are DEPTH + RD_LAT + 2 from the start cycle.
    task automatic test_sweep(input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                              input logic [DW-1:0] want, input logic [DW-1:0] exp_in);
        int  busy1, busy2, lat1, lat2;
        logic d_first, exp_pass;
        busy1 = 0; busy2 = 0; lat1 = 0; lat2 = 0; d_first = 1'b1;
        next_cycle();
        hot_a = ha; hot_d = hd; exp_sig = exp_in; fn_req = 1'b0;
        bist_en = 1'b1; bist_start = 1'b1;
        exp_pass = CmpEn && (want == exp_sig);
        sample();
        for (int n = 1; n <= 3000; n++) begin
            next_cycle();
            bist_start = 1'b0;
            sample();
            if (n == 1) d_first = bist_done1;
            if (bist_busy1) busy1++;
            if (bist_busy2) busy2++;
            if (bist_done1 && lat1 == 0) lat1 = n;
            if (bist_done2 && lat2 == 0) lat2 = n;
            if (lat1 != 0 && lat2 != 0) break;
        end
        checks++;
        if (d_first !== 1'b0) begin
            errors++;
            $display("FAIL sweep_done_cleared got %0b want 0", d_first);
        end
        checks++;
        if (busy1 != 2050 || busy2 != 2051) begin
            errors++;
            $display("FAIL sweep_busy_cycles got %0d/%0d want 2050/2051", busy1, busy2);
        end
        checks++;
        if (lat1 != 2051 || lat2 != 2052) begin
            errors++;
            $display("FAIL sweep_done_latency got %0d/%0d want 2051/2052", lat1, lat2);
        end
        checks++;
        if (bist_sig1 !== want || bist_sig2 !== want) begin
            errors++;
            $display("FAIL sweep_sig got %0h/%0h want %0h", bist_sig1, bist_sig2, want);
        end
        checks++;
        if (bist_pass1 !== exp_pass || bist_pass2 !== exp_pass) begin
            errors++;
            $display("FAIL sweep_pass got %0b/%0b want %0b", bist_pass1, bist_pass2, exp_pass);
        end
        next_cycle();
        fn_req = 1'b1; fn_addr = 11'h003;
        sample();
        checks++;
        if ({fn_gnt1, rom_ren1, fn_gnt2, rom_ren2} !== 4'b0000) begin
            errors++;
            $display("FAIL done_port_idle got gnt=%0b ren=%0b want 0 0", fn_gnt1, rom_ren1);
        end
        next_cycle();
        bist_en = 1'b0;
        sample();
        next_cycle();
        sample();
        checks++;
        if ({fn_gnt1, bist_done1, bist_sig1, fn_gnt2, bist_done2} !== {1'b1, 1'b1, want, 2'b11})
        begin
            errors++;
            $display("FAIL done_exit got gnt=%0b done=%0b sig=%0h want 1 1 %0h", fn_gnt1,
                     bist_done1, bist_sig1, want);
        end
        next_cycle();
        fn_req = 1'b0;
    endtask

    task automatic test_same_cycle();
        do_reset();
        next_cycle();
        hot_a = 11'h033; hot_d = 16'h1234;
        fn_req = 1'b1; fn_addr = 11'h033; bist_en = 1'b1; bist_start = 1'b1;
        sample();
        checks++;
        if ({fn_gnt2, rom_ren2, rom_addr2} !== {1'b1, 1'b1, 11'h033}) begin
            errors++;
            $display("FAIL same_grant got gnt=%0b ren=%0b addr=%0h want 1 1 033", fn_gnt2,
                     rom_ren2, rom_addr2);
        end
        next_cycle();
        bist_start = 1'b0;
        sample();
        checks++;
        if ({fn_gnt2, rom_ren2, bist_busy2} !== 3'b001) begin
            errors++;
            $display("FAIL same_wait got gnt=%0b ren=%0b busy=%0b want 0 0 1", fn_gnt2,
                     rom_ren2, bist_busy2);
        end
        next_cycle();
        sample();
        checks++;
        if ({fn_rvalid2, fn_rdata2, rom_ren2} !== {1'b1, 16'h1234, 1'b0}) begin
            errors++;
            $display("FAIL same_return got vld=%0b data=%0h ren=%0b want 1 1234 0", fn_rvalid2,
                     fn_rdata2, rom_ren2);
        end
        next_cycle();
        sample();
        checks++;
        if ({rom_ren2, fn_gnt2} !== 2'b00) begin
            errors++;
            $display("FAIL same_drain got ren=%0b gnt=%0b want 0 0", rom_ren2, fn_gnt2);
        end
        next_cycle();
        sample();
        checks++;
        if ({rom_ren2, rom_addr2} !== {1'b1, 11'h000}) begin
            errors++;
            $display("FAIL same_first_bist got ren=%0b addr=%0h want 1 000", rom_ren2,
                     rom_addr2);
        end
        next_cycle();
        sample();
        checks++;
        if ({rom_ren2, rom_addr2} !== {1'b1, 11'h001}) begin
            errors++;
            $display("FAIL same_second_bist got ren=%0b addr=%0h want 1 001", rom_ren2,
                     rom_addr2);
        end
        fn_req = 1'b0;
    endtask

    task automatic test_abort();
        logic found;
        found = 1'b0;
        do_reset();
        next_cycle();
        hot_d = 16'h0000; bist_en = 1'b1; bist_start = 1'b1;
        sample();
        for (int n = 0; n < 400; n++) begin
            next_cycle();
            bist_start = 1'b0;
            sample();
            if (rom_ren1 && rom_addr1 == 11'h0FF) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL abort_reach_0ff got %0b want 1", found);
        end
        next_cycle();
        bist_en = 1'b0;
        sample();
        checks++;
        if ({rom_ren1, bist_busy1} !== 2'b01) begin
            errors++;
            $display("FAIL abort_stop got ren=%0b busy=%0b want 0 1", rom_ren1, bist_busy1);
        end
        next_cycle();
        sample();
        checks++;
        if ({rom_ren1, bist_busy1} !== 2'b01) begin
            errors++;
            $display("FAIL abort_flush got ren=%0b busy=%0b want 0 1", rom_ren1, bist_busy1);
        end
        next_cycle();
        fn_req = 1'b1; fn_addr = 11'h012;
        sample();
        checks++;
        if ({bist_busy1, bist_done1, fn_gnt1, rom_addr1} !== {3'b001, 11'h012}) begin
            errors++;
            $display("FAIL abort_idle got busy=%0b done=%0b gnt=%0b addr=%0h want 0 0 1 012",
                     bist_busy1, bist_done1, fn_gnt1, rom_addr1);
        end
        next_cycle();
        fn_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] s;
        logic found;
        found = 1'b0;
        s = '0;
        for (int a = 0; a < 2048; a++) begin
            s = {s[DW-2:0], 1'b0} ^ (s[DW-1] ? 16'h100B : 16'h0000) ^
                ((a == 16) ? 16'hA5A5 : 16'h0000);
        end
        do_reset();
        next_cycle();
        hot_a = 11'h010; hot_d = 16'hA5A5; bist_en = 1'b1; bist_start = 1'b1;
        sample();
        for (int n = 0; n < 1200; n++) begin
            next_cycle();
            bist_start = 1'b0;
            sample();
            if (rom_ren1 && rom_addr1 == 11'h400) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_reach_400 got %0b want 1", found);
        end
        next_cycle();
        rst = 1'b1;
        sample();
        checks++;
        if ({fn_gnt1, fn_rvalid1, fn_rdata1, bist_busy1, bist_done1, bist_sig1, bist_pass1,
             rom_ren1, rom_addr1, bist_busy2, bist_sig2} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got busy=%0b sig=%0h ren=%0b addr=%0h want all 0",
                     bist_busy1, bist_sig1, rom_ren1, rom_addr1);
        end
        next_cycle();
        rst = 1'b0;
        sample();
        checks++;
        if ({fn_rvalid1, bist_busy1, fn_rvalid2, bist_busy2} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_no_returns got rvalid=%0b busy=%0b want 0 0", fn_rvalid1,
                     bist_busy1);
        end
        test_sweep(11'h010, 16'hA5A5, s, s);
    endtask

    initial begin
        test_reset();
        test_functional();
        test_sweep(11'h000, 16'h0000, 16'h0000, 16'h0000);
        test_sweep(11'h7FF, 16'h0001, 16'h0001, 16'h0001);
        test_sweep(11'h7FF, 16'h0001, 16'h0001, 16'h0002);
        test_sweep(11'h7FE, 16'h8000, 16'h100B, 16'h100B);
        test_same_cycle();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
